envelope_gen: RTL and testbench

ENVELOPE_GEN -- requirements
Module: envelope_gen

---
 rtl/envelope_gen.sv | 153 +++++++++++++++
 tb/tb_envelope_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_gen.sv
// ---------------------------------------------------------------------------
// envelope_gen
// ADSR-style gain envelope for one note. A note_start pulse latches the note
// length in beats, clears the gain and starts the attack ramp. The gain ramps
// on audio sample ticks; the beat tick counts the note length down and forces
// the release phase when it expires. done pulses once when the release ramp
// reaches zero.
//
// Ports
//   i_clk           system clock, all state on rising edge
//   i_rst_n         asynchronous active-low reset
//   i_note_start    one-cycle pulse, begin (or retrigger) a note
//   i_duration      note length in beats, sampled on i_note_start
//   i_beat          one-cycle beat tick
//   i_sample_ready  one-cycle audio sample tick
//   o_start         latched duration of the current note
//   o_curr          beats remaining
//   o_multiple      envelope gain
//   o_active        high whenever the envelope is not idle
//   o_done          one-cycle pulse when the release ramp reaches zero
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no note; beat and sample ticks ignored, outputs hold
// S_ATTACK  | gain rises by ATTACK_STEP per sample, saturating at 255
// S_DECAY   | gain falls by DECAY_STEP per sample down to SUSTAIN_LEVEL
// S_SUSTAIN | gain held while beats count the note down
// S_RELEASE | gain falls by RELEASE_STEP per sample to zero, then done
// ---------------------------------------------------------------------------
module envelope_gen #(
    parameter logic [7:0] ATTACK_STEP   = 8'd32,
    parameter logic [7:0] DECAY_STEP    = 8'd4,
    parameter logic [7:0] SUSTAIN_LEVEL = 8'd160,
    parameter logic [7:0] RELEASE_STEP  = 8'd8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_note_start,
    input  logic [5:0] i_duration,
    input  logic       i_beat,
    input  logic       i_sample_ready,
    output logic [5:0] o_start,
    output logic [5:0] o_curr,
    output logic [7:0] o_multiple,
    output logic       o_active,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_start, w_start_nxt;
    logic [5:0] r_curr,  w_curr_nxt;
    logic [7:0] r_mult,  w_mult_nxt;
    logic       r_active;
    logic       r_done,  w_done_nxt;

    logic [8:0] w_attack_sum;
    logic [8:0] w_decay_floor;

    // 9-bit arithmetic so the saturating compares cannot wrap
    assign w_attack_sum  = {1'b0, r_mult} + {1'b0, ATTACK_STEP};
    assign w_decay_floor = {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP};

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_curr_nxt  = r_curr;
        w_mult_nxt  = r_mult;
        w_done_nxt  = 1'b0;

        if (i_note_start) begin
            // Retrigger from any state; same-cycle ticks are dropped
            w_start_nxt = i_duration;
            w_curr_nxt  = i_duration;
            w_mult_nxt  = 8'd0;
            w_state_nxt = (i_duration != 6'd0) ? S_ATTACK : S_RELEASE;
        end else if (r_state != S_IDLE) begin
            if (i_sample_ready) begin
                case (r_state)
                    S_ATTACK: begin
                        if (w_attack_sum >= 9'd255) begin
                            w_mult_nxt  = 8'd255;
                            w_state_nxt = S_DECAY;
                        end else begin
                            w_mult_nxt  = w_attack_sum[7:0];
                        end
                    end
                    S_DECAY: begin
                        if ({1'b0, r_mult} > w_decay_floor) begin
                            w_mult_nxt  = r_mult - DECAY_STEP;
                        end else begin
                            w_mult_nxt  = SUSTAIN_LEVEL;
                            w_state_nxt = S_SUSTAIN;
                        end
                    end
                    S_RELEASE: begin
                        if (r_mult > RELEASE_STEP) begin
                            w_mult_nxt  = r_mult - RELEASE_STEP;
                        end else begin
                            w_mult_nxt  = 8'd0;
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Evaluated after the gain rules so a note expiring on this beat
            // overrides any attack/decay transition
            if (i_beat && (r_curr != 6'd0)) begin
                w_curr_nxt = r_curr - 6'd1;
                if ((r_curr == 6'd1) &&
                    ((r_state == S_ATTACK) || (r_state == S_DECAY) ||
                     (r_state == S_SUSTAIN))) begin
                    w_state_nxt = S_RELEASE;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_start  <= 6'd0;
            r_curr   <= 6'd0;
            r_mult   <= 8'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            r_curr   <= w_curr_nxt;
            r_mult   <= w_mult_nxt;
            r_active <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign o_start    = r_start;
    assign o_curr     = r_curr;
    assign o_multiple = r_mult;
    assign o_active   = r_active;
    assign o_done     = r_done;

endmodule

// File: tb/tb_envelope_gen.sv
module tb_envelope_gen;

    logic       clk;
    logic       rst_n;
    logic       note_start;
    logic [5:0] duration;
    logic       beat;
    logic       sample_ready;
    logic [5:0] start_o;
    logic [5:0] curr_o;
    logic [7:0] mult_o;
    logic       active_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;

    envelope_gen dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_note_start   (note_start),
        .i_duration     (duration),
        .i_beat         (beat),
        .i_sample_ready (sample_ready),
        .o_start        (start_o),
        .o_curr         (curr_o),
        .o_multiple     (mult_o),
        .o_active       (active_o),
        .o_done         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, are captured on the next rising edge
    // and outputs are observed on the following falling edge.
    task automatic drive(input logic ns, input logic [5:0] d, input logic b, input logic s);
        note_start   = ns;
        duration     = d;
        beat         = b;
        sample_ready = s;
        @(negedge clk);
        note_start   = 1'b0;
        beat         = 1'b0;
        sample_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        note_start = 1'b0; duration = 6'd0; beat = 1'b0; sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL reset_mult got %0d want 0", mult_o); end
        checks++; if (curr_o !== 6'd0) begin errors++; $display("FAIL reset_curr got %0d want 0", curr_o); end
        checks++; if (start_o !== 6'd0) begin errors++; $display("FAIL reset_start got %0d want 0", start_o); end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore;
        drive(1'b0, 6'd9, 1'b1, 1'b1);
        drive(1'b0, 6'd9, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL idle_mult got %0d want 0", mult_o); end
        checks++; if (curr_o !== 6'd0) begin errors++; $display("FAIL idle_curr got %0d want 0", curr_o); end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL idle_active got %b want 0", active_o); end
    endtask

    task automatic test_attack;
        int exp_m;
        drive(1'b1, 6'd5, 1'b0, 1'b0);
        checks++; if (start_o !== 6'd5) begin errors++; $display("FAIL att_start got %0d want 5", start_o); end
        checks++; if (curr_o !== 6'd5) begin errors++; $display("FAIL att_curr got %0d want 5", curr_o); end
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL att_mult0 got %0d want 0", mult_o); end
        checks++; if (active_o !== 1'b1) begin errors++; $display("FAIL att_active got %b want 1", active_o); end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 6'd0, 1'b0, 1'b1);
            exp_m = (i * 32 > 255) ? 255 : i * 32;
            checks++;
            if (mult_o !== exp_m[7:0]) begin
                errors++; $display("FAIL att_ramp[%0d] got %0d want %0d", i, mult_o, exp_m);
            end
        end
        checks++; if (curr_o !== 6'd5) begin errors++; $display("FAIL att_curr_end got %0d want 5", curr_o); end
    endtask

    task automatic test_decay;
        int exp_m;
        for (int i = 1; i <= 24; i++) begin
            drive(1'b0, 6'd0, 1'b0, 1'b1);
            exp_m = (255 - 4 * i < 160) ? 160 : 255 - 4 * i;
            checks++;
            if (mult_o !== exp_m[7:0]) begin
                errors++; $display("FAIL dec_ramp[%0d] got %0d want %0d", i, mult_o, exp_m);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'd0, 1'b0, 1'b1);
            checks++;
            if (mult_o !== 8'd160) begin
                errors++; $display("FAIL sus_hold[%0d] got %0d want 160", i, mult_o);
            end
        end
    endtask

    task automatic test_release;
        int exp_m;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 6'd0, 1'b1, 1'b0);
            checks++;
            if (curr_o !== 6'(5 - i)) begin
                errors++; $display("FAIL rel_beat[%0d] got %0d want %0d", i, curr_o, 5 - i);
            end
        end
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 6'd0, 1'b0, 1'b1);
            exp_m = 160 - 8 * i;
            checks++;
            if (mult_o !== exp_m[7:0]) begin
                errors++; $display("FAIL rel_ramp[%0d] got %0d want %0d", i, mult_o, exp_m);
            end
            checks++;
            if (done_o !== (i == 20)) begin
                errors++; $display("FAIL rel_done[%0d] got %b want %b", i, done_o, (i == 20));
            end
        end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL rel_active got %b want 0", active_o); end
        drive(1'b0, 6'd0, 1'b1, 1'b1);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rel_done_once got %b want 0", done_o); end
        checks++; if (curr_o !== 6'd0) begin errors++; $display("FAIL rel_nowrap got %0d want 0", curr_o); end
        checks++; if (start_o !== 6'd5) begin errors++; $display("FAIL rel_start_hold got %0d want 5", start_o); end
    endtask

    task automatic test_zero_duration;
        drive(1'b1, 6'd0, 1'b0, 1'b0);
        checks++; if (active_o !== 1'b1) begin errors++; $display("FAIL zero_active got %b want 1", active_o); end
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL zero_mult got %0d want 0", mult_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_early_done got %b want 0", done_o); end
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done_o); end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL zero_idle got %b want 0", active_o); end
        drive(1'b0, 6'd0, 1'b0, 1'b0);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done_o); end
    endtask

    task automatic test_retrigger;
        drive(1'b1, 6'd2, 1'b0, 1'b0);
        repeat (32) drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd160) begin errors++; $display("FAIL rt_sustain got %0d want 160", mult_o); end
        repeat (2) drive(1'b0, 6'd0, 1'b1, 1'b0);
        repeat (10) drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd80) begin errors++; $display("FAIL rt_rel80 got %0d want 80", mult_o); end
        drive(1'b1, 6'd3, 1'b1, 1'b1);
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL rt_mult got %0d want 0", mult_o); end
        checks++; if (curr_o !== 6'd3) begin errors++; $display("FAIL rt_curr got %0d want 3", curr_o); end
        checks++; if (start_o !== 6'd3) begin errors++; $display("FAIL rt_start got %0d want 3", start_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rt_done got %b want 0", done_o); end
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd32) begin errors++; $display("FAIL rt_attack got %0d want 32", mult_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rt_done2 got %b want 0", done_o); end
    endtask

    task automatic test_beat_override;
        drive(1'b1, 6'd1, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd32) begin errors++; $display("FAIL bo_att got %0d want 32", mult_o); end
        drive(1'b0, 6'd0, 1'b1, 1'b1);
        checks++; if (mult_o !== 8'd64) begin errors++; $display("FAIL bo_mult got %0d want 64", mult_o); end
        checks++; if (curr_o !== 6'd0) begin errors++; $display("FAIL bo_curr got %0d want 0", curr_o); end
        drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd56) begin errors++; $display("FAIL bo_release got %0d want 56", mult_o); end
    endtask

    task automatic test_reset_mid_note;
        drive(1'b1, 6'd4, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 6'd0, 1'b0, 1'b1);
        checks++; if (mult_o !== 8'd96) begin errors++; $display("FAIL rm_pre got %0d want 96", mult_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mult_o !== 8'd0) begin errors++; $display("FAIL rm_mult got %0d want 0", mult_o); end
        checks++; if (curr_o !== 6'd0) begin errors++; $display("FAIL rm_curr got %0d want 0", curr_o); end
        checks++; if (start_o !== 6'd0) begin errors++; $display("FAIL rm_start got %0d want 0", start_o); end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL rm_active got %b want 0", active_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 6'd0, 1'b1, 1'b1);
            checks++;
            if (done_o !== 1'b0 || active_o !== 1'b0) begin
                errors++; $display("FAIL rm_after[%0d] got done=%b active=%b want 0 0", i, done_o, active_o);
            end
        end
        drive(1'b1, 6'd2, 1'b0, 1'b0);
        checks++;
        if (start_o !== 6'd2 || curr_o !== 6'd2 || mult_o !== 8'd0 || active_o !== 1'b1) begin
            errors++; $display("FAIL rm_new_note got start=%0d curr=%0d mult=%0d active=%b want 2 2 0 1",
                               start_o, curr_o, mult_o, active_o);
        end
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_attack;
        test_decay;
        test_release;
        test_zero_duration;
        test_retrigger;
        test_beat_override;
        test_reset_mid_note;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
